// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) unit.
// Produces a 2*WIDTH HI/LO result with a one-cycle done pulse.
module mul_div_unit #(
   parameter int         WIDTH  = 32,
   parameter logic [4:0] OP_MUL = 5'b01111,
   parameter logic [4:0] OP_DIV = 5'b10000
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   input_a,
   input  logic [WIDTH-1:0]   input_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] mq_q;
   logic [WIDTH-1:0] m_q;
   logic             q1_q;
   logic             is_div_q;
   logic             neg_quo_q;
   logic             neg_rem_q;

   logic             op_ok;
   logic             div_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_s;
   logic [WIDTH-1:0] quo_s;

   always_comb begin
      op_ok    = start && (opcode == OP_MUL || opcode == OP_DIV);
      div_zero = (opcode == OP_DIV) && (input_b == '0);
      a_mag    = input_a[WIDTH-1] ? -input_a : input_a;
      b_mag    = input_b[WIDTH-1] ? -input_b : input_b;
      m_ext    = {m_q[WIDTH-1], m_q};
      unique case ({mq_q[0], q1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
      // remainder stays below the divisor magnitude, so its top bit is free
      shifted = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
      diff    = {1'b0, shifted} - {1'b0, m_q};
      rem_s   = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      quo_s   = neg_quo_q ? -mq_q : mq_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (op_ok) state_d = div_zero ? DONE : RUN;
         end
         RUN: begin
            if (count_q == LAST) state_d = FIX;
         end
         FIX: state_d = DONE;
         DONE: begin
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         result      <= '0;
         count_q     <= '0;
         acc_q       <= '0;
         mq_q        <= '0;
         m_q         <= '0;
         q1_q        <= 1'b0;
         is_div_q    <= 1'b0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (op_ok) begin
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  div_by_zero <= div_zero;
                  count_q     <= '0;
                  acc_q       <= '0;
                  q1_q        <= 1'b0;
                  is_div_q    <= (opcode == OP_DIV);
                  neg_quo_q   <= input_a[WIDTH-1] ^ input_b[WIDTH-1];
                  neg_rem_q   <= input_a[WIDTH-1];
                  if (opcode == OP_DIV) begin
                     mq_q <= a_mag;
                     m_q  <= b_mag;
                  end else begin
                     mq_q <= input_b;
                     m_q  <= input_a;
                  end
                  if (div_zero) result <= {input_a, {WIDTH{1'b1}}};
               end
            end
            RUN: begin
               count_q <= count_q + CW'(1);
               if (is_div_q) begin
                  if (!diff[WIDTH]) begin
                     acc_q <= {1'b0, diff[WIDTH-1:0]};
                     mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_q <= {1'b0, shifted};
                     mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  {acc_q, mq_q, q1_q} <= {booth_sum[WIDTH], booth_sum, mq_q};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (is_div_q) result <= {rem_s, quo_s};
               else          result <= {acc_q[WIDTH-1:0], mq_q};
            end
            DONE: begin
               // divide-by-zero arrives here with done low and pulses one cycle later
               if (done) begin
                  done <= 1'b0;
                  busy <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit.
// Reference model uses plain 64-bit integer arithmetic.
module tb_mul_div_unit;

   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [4:0]  opcode;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   mul_div_unit #(
      .WIDTH  (32),
      .OP_MUL (OP_MUL),
      .OP_DIV (OP_DIV)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .opcode      (opcode),
      .input_a     (input_a),
      .input_b     (input_b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input bit is_div,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) return 64'(sa * sb);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 1000)) - 32'd500;
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // called at a negedge; returns at the negedge in the cycle after done
   task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
      bit          is_div;
      logic [63:0] exp;
      int          exp_lat;
      int          lat;
      is_div  = (op == OP_DIV);
      exp     = model(is_div, a, b);
      exp_lat = (is_div && b == 32'd0) ? 1 : 33;
      start   = 1'b1;
      opcode  = op;
      input_a = a;
      input_b = b;
      @(negedge clk);
      start   = 1'b0;
      opcode  = 5'($urandom);
      input_a = $urandom;
      input_b = $urandom;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, result, exp);
      check({tag, "_dz"}, 64'(div_by_zero), 64'(is_div && b == 32'd0));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int  lat;
      bit  seen;
      logic [4:0] op;
      clr     = 1'b1;
      start   = 1'b0;
      opcode  = '0;
      input_a = '0;
      input_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      check("rst_res", result, 64'd0);
      clr = 1'b0;
      @(negedge clk);

      run_op(OP_MUL, 32'd723, 32'd19, "mul_pos");
      check("mul_pos_const", result, 64'h0000_0000_0000_35A9);
      run_op(OP_MUL, -32'sd723, 32'd19, "mul_neg");
      check("mul_neg_const", result, 64'hFFFF_FFFF_FFFF_CA57);
      run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, "mul_min");
      check("mul_min_const", result, 64'h4000_0000_0000_0000);
      run_op(OP_DIV, 32'd780, 32'd40, "div_pos");
      check("div_pos_const", result, 64'h0000_0014_0000_0013);
      run_op(OP_DIV, -32'sd780, 32'd40, "div_neg");
      check("div_neg_const", result, 64'hFFFF_FFEC_FFFF_FFED);
      run_op(OP_DIV, 32'd5, 32'd0, "div_zero");
      check("div_zero_const", result, 64'h0000_0005_FFFF_FFFF);
      run_op(OP_MUL, 32'd3, 32'd4, "dz_clear");
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf_const", result, 64'h0000_0000_8000_0000);

      // second start while busy must be ignored
      start   = 1'b1;
      opcode  = OP_MUL;
      input_a = 32'd1000;
      input_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      start   = 1'b1;
      input_a = 32'd77;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      check("busy_start_lat", 64'(lat), 64'd23);
      check("busy_start_res", result, 64'd3000);
      @(negedge clk);

      // unsupported opcode produces nothing
      start  = 1'b1;
      opcode = 5'b00011;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      repeat (40) begin
         if (busy || done) seen = 1'b1;
         @(negedge clk);
      end
      check("bad_op", 64'(seen), 64'd0);

      // clr aborts a divide in flight
      start   = 1'b1;
      opcode  = OP_DIV;
      input_a = 32'd780;
      input_b = 32'd40;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_res", result, 64'd0);
      check("clr_done", 64'(done), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      check("clr_no_done", 64'(seen), 64'd0);
      run_op(OP_MUL, 32'd6, 32'd7, "after_clr");
      check("after_clr_const", result, 64'd42);

      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
         run_op(op, pick(), pick(), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle signed multiply/divide responder for the datapath's MUL (opcode 01111) and DIV (opcode 10000) operations.
- The control unit or bench issues a one-cycle start with operands and opcode. The unit iterates over 32 cycles, then returns a 64-bit HI/LO result with a one-cycle done pulse.
- The result feeds the HI/LO register pair. It replaces the single-cycle combinational mul/div path.

Parameters:
WIDTH, 32, operand width; result width is 2*WIDTH
OP_MUL, 5'b01111, opcode for signed multiply
OP_DIV, 5'b10000, opcode for signed divide

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
start  input  1  request strobe; sampled only when busy=0
opcode  input  5  OP_MUL or OP_DIV; sampled with start
input_a  input  WIDTH  multiplicand / dividend (two's complement); latched at start
input_b  input  WIDTH  multiplier / divisor (two's complement); latched at start
busy  output  1  high from the cycle after start is accepted until done deasserts
done  output  1  one-cycle pulse; result valid in this cycle
result  output  2*WIDTH  MUL: full signed product; DIV: {remainder[63:32], quotient[31:0]}
div_by_zero  output  1  set with done when DIV had input_b==0; cleared on next accepted start

Behaviour:
- Reset: while clr=1 at a clock edge, state<=IDLE; busy, done, div_by_zero <= 0; result <= 0; counter <= 0.
- clr wins over every other event and aborts any operation in flight; no done is produced for the aborted request.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: when start=1 and opcode is OP_MUL or OP_DIV, latch operands and opcode, counter<=0, go to RUN.
- IDLE, other opcodes: start with any other opcode is ignored (stay IDLE, no done).
- IDLE, DIV by zero: for OP_DIV with input_b==0, go directly to DONE. result <= {input_a, 32'hFFFFFFFF}, div_by_zero <= 1.
- RUN, MUL: radix-2 Booth, one step per cycle on the {acc, multiplier, q-1} register.
- RUN, DIV: restoring division on operand magnitudes, one quotient bit per cycle.
- RUN exit: after 32 iterations (counter==31 at the edge), go to FIX.
- FIX: DIV applies signs. Quotient is negated if sign(a)^sign(b). Remainder takes the sign of the dividend (truncating division). MUL passes the product through. Result register is loaded; go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+33 (34 cycles). Divide-by-zero gives done in the cycle after edge k+1.
- busy is 1 in RUN/FIX/DONE and 0 in IDLE. start while busy=1 is ignored; no queuing.
- result holds its value after done until the next completion or clr. Operand changes after the start cycle have no effect.
- Width rules: all arithmetic is two's complement. MUL produces the exact 64-bit product.
- DIV overflow (0x80000000 / -1): quotient wraps to 0x80000000, remainder 0, div_by_zero=0.
- Back-to-back: a start in the cycle immediately after done (state IDLE) is accepted.

Test Plan:
- MUL 723 * 19: start with opcode 01111 -> done in the 34th cycle after the start cycle, result=64'h0000_0000_0000_35A9, busy low after done.
- MUL -723 * 19 -> result=64'hFFFF_FFFF_FFFF_CA57; 0x80000000 * 0x80000000 -> 64'h4000_0000_0000_0000.
- DIV 780 / 40 -> result=64'h0000_0014_0000_0013. DIV -780 / 40 -> result=64'hFFFF_FFEC_FFFF_FFED (quotient -19, remainder -20).
- DIV 5 / 0 -> done 2 cycles after start, div_by_zero=1, result=64'h0000_0005_FFFF_FFFF. A following MUL start clears div_by_zero.
- Start MUL, change input_a and pulse start again at cycle 10 -> second start ignored, result equals the first product. Start with opcode 00011 -> no busy, no done.
- Start DIV, assert clr at cycle 15 for one cycle -> busy=0, result=0, no done pulse. A new MUL 6 * 7 afterwards -> result=42.
